// File: rtl/csa_slice_seq_if.sv
// Operand, slice and result signals between the carry-select sequencer and its environment.
// The slave modport is the sequencer; the master modport is the operand source, slice and result sink.
interface csa_slice_seq_if #(
  parameter int WIDTH   = 8,
  parameter int NSLICES = 4
);
  localparam int IDXW = $clog2(NSLICES);

  logic                     in_valid;
  logic                     in_ready;
  logic [NSLICES*WIDTH-1:0] a;
  logic [NSLICES*WIDTH-1:0] b;
  logic                     c_in;
  logic [WIDTH-1:0]         slice_a;
  logic [WIDTH-1:0]         slice_b;
  logic [WIDTH-1:0]         slice_s0;
  logic [WIDTH-1:0]         slice_s1;
  logic                     slice_c0;
  logic                     slice_c1;
  logic [IDXW-1:0]          slice_idx;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [NSLICES*WIDTH-1:0] sum;
  logic                     c_out;

  modport slave (
    input  in_valid, a, b, c_in, slice_s0, slice_s1, slice_c0, slice_c1, out_ready,
    output in_ready, slice_a, slice_b, slice_idx, busy, out_valid, sum, c_out
  );

  modport master (
    output in_valid, a, b, c_in, slice_s0, slice_s1, slice_c0, slice_c1, out_ready,
    input  in_ready, slice_a, slice_b, slice_idx, busy, out_valid, sum, c_out
  );
endinterface

// File: rtl/csa_slice_seq.sv
// Multi-cycle wide adder sequencer: feeds one chunk per cycle to an external dual-sum
// carry-select slice, picks the sum/carry with the registered running carry, and holds the result.
module csa_slice_seq #(
  parameter int WIDTH   = 8,
  parameter int NSLICES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_slice_seq_if.slave  bus
);
  localparam int IDXW = $clog2(NSLICES);
  localparam int TOTW = NSLICES * WIDTH;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [TOTW-1:0]   a_q, a_d;
  logic [TOTW-1:0]   b_q, b_d;
  logic [TOTW-1:0]   sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic [WIDTH-1:0]  sel_sum;
  logic              sel_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // Running carry selects between the two precomputed slice results.
  assign sel_sum   = carry_q ? bus.slice_s1 : bus.slice_s0;
  assign sel_carry = carry_q ? bus.slice_c1 : bus.slice_c0;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    c_out_d       = c_out_q;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    bus.slice_a   = '0;
    bus.slice_b   = '0;
    bus.slice_idx = '0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy      = 1'b1;
        bus.slice_a   = a_q[idx_q*WIDTH +: WIDTH];
        bus.slice_b   = b_q[idx_q*WIDTH +: WIDTH];
        bus.slice_idx = idx_q;
        sum_d[idx_q*WIDTH +: WIDTH] = sel_sum;
        carry_d = sel_carry;
        if (idx_q == LAST_IDX) begin
          c_out_d = sel_carry;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_csa_slice_seq.sv
// Randomized bench for csa_slice_seq in two configurations, checked against plain wide addition.
module tb_csa_slice_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  csa_slice_seq_if #(.WIDTH(8), .NSLICES(4)) bus8 ();
  csa_slice_seq_if #(.WIDTH(4), .NSLICES(3)) bus4 ();

  csa_slice_seq #(.WIDTH(8), .NSLICES(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  csa_slice_seq #(.WIDTH(4), .NSLICES(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  // Behavioural dual-sum slices
  assign {bus8.slice_c0, bus8.slice_s0} = {1'b0, bus8.slice_a} + {1'b0, bus8.slice_b};
  assign {bus8.slice_c1, bus8.slice_s1} = {1'b0, bus8.slice_a} + {1'b0, bus8.slice_b} + 9'd1;
  assign {bus4.slice_c0, bus4.slice_s0} = {1'b0, bus4.slice_a} + {1'b0, bus4.slice_b};
  assign {bus4.slice_c1, bus4.slice_s1} = {1'b0, bus4.slice_a} + {1'b0, bus4.slice_b} + 5'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic noise8();
    bus8.in_valid  = 1'($urandom);
    bus8.a         = $urandom;
    bus8.b         = $urandom;
    bus8.c_in      = 1'($urandom);
    bus8.out_ready = 1'($urandom);
  endtask

  task automatic noise4();
    bus4.in_valid  = 1'($urandom);
    bus4.a         = 12'($urandom);
    bus4.b         = 12'($urandom);
    bus4.c_in      = 1'($urandom);
    bus4.out_ready = 1'($urandom);
  endtask

  task automatic op8(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                     input int pre, input int hold, input bit noise);
    logic [32:0] expv;
    int n;
    expv = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    repeat (pre) begin @(posedge clk); #1; end
    bus8.in_valid = 1'b1; bus8.a = av; bus8.b = bv; bus8.c_in = cv; bus8.out_ready = 1'b0;
    n = 0;
    while (!bus8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_ready", bus8.in_ready, 1);
    @(posedge clk); #1;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      if (noise) noise8(); else bus8.in_valid = 1'b0;
      check("run_busy", bus8.busy, 1);
      check("run_idx", bus8.slice_idx, n);
      check("run_slice_a", bus8.slice_a, (av >> (8 * n)) & 32'hFF);
      check("run_slice_b", bus8.slice_b, (bv >> (8 * n)) & 32'hFF);
      check("run_in_ready", bus8.in_ready, 0);
      @(posedge clk); #1; n++;
    end
    check("latency8", n, 4);
    check("sum8", bus8.sum, expv[31:0]);
    check("cout8", bus8.c_out, expv[32]);
    repeat (hold) begin
      if (noise) noise8();
      bus8.out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_sum8", bus8.sum, expv[31:0]);
      check("hold_cout8", bus8.c_out, expv[32]);
      check("hold_valid8", bus8.out_valid, 1);
      check("hold_in_ready8", bus8.in_ready, 0);
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("idle_in_ready8", bus8.in_ready, 1);
    check("idle_valid8", bus8.out_valid, 0);
    check("idle_busy8", bus8.busy, 0);
    check("idle_slice_a8", bus8.slice_a, 0);
    check("idle_sum_kept8", bus8.sum, expv[31:0]);
  endtask

  task automatic op4(input logic [11:0] av, input logic [11:0] bv, input logic cv,
                     input int pre, input int hold);
    logic [12:0] expv;
    int n;
    expv = {1'b0, av} + {1'b0, bv} + {12'd0, cv};
    repeat (pre) begin @(posedge clk); #1; end
    bus4.in_valid = 1'b1; bus4.a = av; bus4.b = bv; bus4.c_in = cv; bus4.out_ready = 1'b0;
    n = 0;
    while (!bus4.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_ready4", bus4.in_ready, 1);
    @(posedge clk); #1;
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      noise4();
      check("run_idx4", bus4.slice_idx, n);
      check("run_slice_a4", bus4.slice_a, (av >> (4 * n)) & 12'hF);
      @(posedge clk); #1; n++;
    end
    check("latency4", n, 3);
    check("sum4", bus4.sum, expv[11:0]);
    check("cout4", bus4.c_out, expv[12]);
    repeat (hold) begin
      noise4();
      bus4.out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_sum4", bus4.sum, expv[11:0]);
      check("hold_valid4", bus4.out_valid, 1);
    end
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check("idle_in_ready4", bus4.in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.c_in = 1'b0; bus4.out_ready = 1'b0;
    repeat (3) begin noise8(); @(posedge clk); #1; end
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.c_out, 0);
    check("rst_slice_a", bus8.slice_a, 0);
    check("rst_slice_idx", bus8.slice_idx, 0);
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    rst_n = 1'b1;

    op8(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 0, 1'b0);
    op8(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 0, 1'b0);
    op8(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);
    op8(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0, 6, 1'b1);
    op8(32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 0, 0, 1'b0);

    // Reset while the third chunk is in flight
    bus8.in_valid = 1'b1; bus8.a = $urandom; bus8.b = $urandom; bus8.c_in = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_idx", bus8.slice_idx, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", bus8.in_ready, 1);
    check("mid_rst_out_valid", bus8.out_valid, 0);
    check("mid_rst_busy", bus8.busy, 0);
    check("mid_rst_sum", bus8.sum, 0);
    check("mid_rst_cout", bus8.c_out, 0);
    check("mid_rst_slice_a", bus8.slice_a, 0);
    check("mid_rst_slice_idx", bus8.slice_idx, 0);
    #1 rst_n = 1'b1;
    op8(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 1000; i++)
      op8($urandom, $urandom, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);

    op4(12'hFFF, 12'h000, 1'b1, 0, 0);
    op4(12'hFFF, 12'hFFF, 1'b1, 0, 2);
    for (int i = 0; i < 500; i++)
      op4(12'($urandom), 12'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
